// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder behind the MEM-stage port.
// One request is accepted per handshake. A counter-driven FSM inserts LATENCY
// wait states, then presents a one-cycle response: load data, a store
// acknowledgement, or an error for a request that is malformed.
module dmem_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2,
   parameter int AW      = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_read,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        err_sticky
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Counter preload on accept; unused when LATENCY is 0 (straight to RESP).
   localparam logic [3:0] LAT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   state_t         state;
   state_t         state_nxt;
   logic [3:0]     cnt;
   logic [3:0]     cnt_nxt;

   logic           accept;
   logic           req_err;
   logic [AW-1:0]  word_idx;

   logic [31:0]    data_q;
   logic           err_q;

   logic [31:0]    mem [DEPTH];

   // ---------------------------------------------------------------------
   // Request decode
   // ---------------------------------------------------------------------

   // Ready is a pure state decode so the stall never depends on req_* inputs.
   assign req_ready = (state != WAIT);
   assign accept    = req_ready & (req_read | req_write);
   assign word_idx  = req_addr[AW+1:2];

   // Rejected: read and write at once, unaligned byte address, or an address
   // beyond the last word of the array.
   assign req_err = (req_read & req_write)
                  | (|req_addr[1:0])
                  | (|req_addr[31:AW+2]);

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------

   // State and wait counter registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state: a new request may be taken in IDLE or in RESP, which is what
   // allows back-to-back transactions every LATENCY+1 cycles.
   always_comb begin
      state_nxt = IDLE;
      cnt_nxt   = cnt;
      case (state)
         IDLE, RESP: begin
            if (accept) begin
               if (LATENCY == 0) begin
                  state_nxt = RESP;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = LAT_LOAD;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               state_nxt = RESP;
            end else begin
               state_nxt = WAIT;
               cnt_nxt   = cnt - 4'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Storage and response data
   // ---------------------------------------------------------------------

   // RAM write commits on the accept edge; contents survive reset.
   always_ff @(posedge clock) begin
      if (accept && req_write && !req_err) begin
         mem[word_idx] <= req_wdata;
      end
   end

   // Response register: load data is captured at accept and held through the
   // wait states. Stores and rejected requests capture zero so resp_rdata is
   // already correct for them.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         data_q <= 32'd0;
         err_q  <= 1'b0;
      end else if (accept) begin
         err_q  <= req_err;
         data_q <= (req_read && !req_err) ? mem[word_idx] : 32'd0;
      end
   end

   // Sticky error flag latches on the edge that ends an error response.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         err_sticky <= 1'b0;
      end else if (state == RESP && err_q) begin
         err_sticky <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs, decoded from registers only
   // ---------------------------------------------------------------------

   assign resp_valid = (state == RESP);
   assign resp_err   = resp_valid & err_q;
   assign resp_rdata = resp_valid ? data_q : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: two responders (LATENCY 2 and LATENCY 0) driven with
// directed and random requests and checked against a word-map reference model.
module tb_dmem_responder;

   logic        clock = 1'b0;
   logic        reset = 1'b0;

   logic        rd     [2];
   logic        wr     [2];
   logic [31:0] addr   [2];
   logic [31:0] wdata  [2];
   logic        rdy    [2];
   logic        vld    [2];
   logic [31:0] rdata  [2];
   logic        rerr   [2];
   logic        sticky [2];

   int checks   = 0;
   int failures = 0;

   // Reference model: word contents keyed by instance*1024 + word index.
   logic [31:0] mdl [int];
   bit          stk [2];

   always #5 clock = ~clock;

   dmem_responder #(.DEPTH(256), .LATENCY(2), .AW(8)) u_lat2 (
      .clock(clock), .reset(reset),
      .req_read(rd[0]), .req_write(wr[0]), .req_addr(addr[0]), .req_wdata(wdata[0]),
      .req_ready(rdy[0]), .resp_valid(vld[0]), .resp_rdata(rdata[0]),
      .resp_err(rerr[0]), .err_sticky(sticky[0])
   );

   dmem_responder #(.DEPTH(256), .LATENCY(0), .AW(8)) u_lat0 (
      .clock(clock), .reset(reset),
      .req_read(rd[1]), .req_write(wr[1]), .req_addr(addr[1]), .req_wdata(wdata[1]),
      .req_ready(rdy[1]), .resp_valid(vld[1]), .resp_rdata(rdata[1]),
      .resp_err(rerr[1]), .err_sticky(sticky[1])
   );

   function automatic int lat_of(input int k);
      return (k == 0) ? 2 : 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One full transaction on instance k, entered just after a negedge with the
   // instance ready; returns at the negedge where the response is visible.
   task automatic txn(input int k, input logic r, input logic w,
                      input logic [31:0] a, input logic [31:0] d);
      int          n;
      int          lowcnt;
      int          key;
      bit          seen;
      bit          known;
      logic        err;
      logic [31:0] exp;
      chk("ready_before", rdy[k], 1);
      rd[k] = r; wr[k] = w; addr[k] = a; wdata[k] = d;
      @(posedge clock); #1;
      rd[k] = 1'b0; wr[k] = 1'b0;
      err   = (r & w) | (a[1:0] != 2'b00) | (a[31:10] != 22'd0);
      key   = k * 1024 + int'(a[9:2]);
      known = 1'b1;
      exp   = 32'd0;
      if (!err && r) begin
         if (mdl.exists(key)) exp = mdl[key];
         else known = 1'b0;
      end
      if (!err && w) mdl[key] = d;
      n = 0; lowcnt = 0; seen = 1'b0;
      while (!seen && n < 20) begin
         @(negedge clock);
         n++;
         if (vld[k]) seen = 1'b1;
         else if (!rdy[k]) lowcnt++;
      end
      chk("resp_seen", seen, 1);
      chk("latency", n, lat_of(k) + 1);
      chk("stall_cycles", lowcnt, lat_of(k));
      chk("resp_err", rerr[k], err);
      if (known) chk("resp_rdata", rdata[k], exp);
      chk("sticky_prior", sticky[k], stk[k]);
      chk("ready_in_resp", rdy[k], 1);
      if (err) stk[k] = 1'b1;
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = 32'd0; wdata[k] = 32'd0; stk[k] = 1'b0;
      end
      repeat (3) @(negedge clock);
      for (int k = 0; k < 2; k++) begin
         chk("rst_ready", rdy[k], 1);
         chk("rst_valid", vld[k], 0);
         chk("rst_rdata", rdata[k], 0);
         chk("rst_err", rerr[k], 0);
         chk("rst_sticky", sticky[k], 0);
      end
      reset = 1'b1;
      @(negedge clock);

      // LATENCY=2 store then load
      txn(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
      txn(0, 1'b1, 1'b0, 32'h10, 32'h0);
      // misaligned load
      txn(0, 1'b1, 1'b0, 32'h13, 32'h0);
      @(negedge clock);
      chk("sticky_after_misalign", sticky[0], 1);
      // read+write together is rejected without a memory effect
      txn(0, 1'b0, 1'b1, 32'h40, 32'hA5A5A5A5);
      txn(0, 1'b1, 1'b1, 32'h40, 32'h55);
      txn(0, 1'b1, 1'b0, 32'h40, 32'h0);
      // out-of-range store leaves word 0 alone
      txn(0, 1'b0, 1'b1, 32'h0, 32'h0BADF00D);
      txn(0, 1'b0, 1'b1, 32'h400, 32'hFFFFFFFF);
      txn(0, 1'b1, 1'b0, 32'h0, 32'h0);

      // LATENCY=0 back-to-back store then load on consecutive cycles
      wr[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'h1234;
      @(posedge clock); #1;
      wr[1] = 1'b0; rd[1] = 1'b1;
      @(negedge clock);
      chk("b2b_wr_valid", vld[1], 1);
      chk("b2b_wr_err", rerr[1], 0);
      chk("b2b_wr_rdata", rdata[1], 0);
      chk("b2b_wr_ready", rdy[1], 1);
      @(posedge clock); #1;
      rd[1] = 1'b0;
      mdl[1024 + 8] = 32'h1234;
      @(negedge clock);
      chk("b2b_rd_valid", vld[1], 1);
      chk("b2b_rd_rdata", rdata[1], 32'h00001234);
      chk("b2b_rd_ready", rdy[1], 1);
      @(negedge clock);
      chk("b2b_idle_valid", vld[1], 0);

      // random traffic on both instances, gaps of 0..2 cycles
      for (int t = 0; t < 150; t++) begin
         for (int k = 0; k < 2; k++) begin
            int          op;
            int          sel;
            logic        r;
            logic        w;
            logic [31:0] a;
            op  = $urandom_range(0, 9);
            sel = $urandom_range(0, 11);
            r   = (op <= 4) || (op == 9);
            w   = (op >= 5);
            a   = 32'($urandom_range(0, 15)) << 2;
            if (sel == 10) a = a | 32'($urandom_range(1, 3));
            if (sel == 11) a = a | (32'h1 << $urandom_range(10, 31));
            txn(k, r, w, a, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clock);
         end
      end

      // reset in the middle of a LATENCY=2 wait
      @(negedge clock);
      rd[0] = 1'b1; addr[0] = 32'h0;
      @(posedge clock); #1;
      rd[0] = 1'b0;
      @(negedge clock);
      chk("mid_wait_stall", rdy[0], 0);
      reset = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst2_ready", rdy[k], 1);
         chk("rst2_valid", vld[k], 0);
         chk("rst2_rdata", rdata[k], 0);
         chk("rst2_sticky", sticky[k], 0);
         stk[k] = 1'b0;
      end
      mdl.delete();
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         chk("no_resp_after_rst", vld[0], 0);
      end
      txn(0, 1'b0, 1'b1, 32'h8, 32'hCAFEF00D);
      txn(0, 1'b1, 1'b0, 32'h8, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
